// File: rtl/cache_2way.sv
// 2-way set-associative write-through data cache, one 32-bit word per line, LRU replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
//
// state   | meaning
// IDLE    | lookup of the incoming request; read hits complete from here
// RD_MISS | waiting for the memory read that fills the victim way
// WR_THRU | waiting for the memory write of a store (hit or miss)
module cache_2way #(
  parameter int SET_BITS = 3,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int SETS  = 2**SET_BITS;
  localparam int TAG_W = ADDR_W - 2 - SET_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state;

  logic [TAG_W-1:0]    tag_mem  [SETS][2];
  logic [31:0]         data_mem [SETS][2];
  logic [1:0]          valid    [SETS];
  logic [SETS-1:0]     lru;

  logic [SET_BITS-1:0] req_set, l_set;
  logic [TAG_W-1:0]    req_tag, l_tag;
  logic [1:0]          hit_vec;
  logic                hit, hit_way, victim, accept, wr_hit, fill;
  logic                unused_addr_bits;

  assign req_set = cpu_addr[SET_BITS+1:2];
  assign req_tag = cpu_addr[ADDR_W-1:SET_BITS+2];
  // mem_addr doubles as the latched request address while a miss or store is in flight
  assign l_set   = mem_addr[SET_BITS+1:2];
  assign l_tag   = mem_addr[ADDR_W-1:SET_BITS+2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    hit_vec[0] = valid[req_set][0] && (tag_mem[req_set][0] == req_tag);
    hit_vec[1] = valid[req_set][1] && (tag_mem[req_set][1] == req_tag);
    hit        = |hit_vec;
    hit_way    = hit_vec[1];
    if (!valid[l_set][0])      victim = 1'b0;
    else if (!valid[l_set][1]) victim = 1'b1;
    else                       victim = lru[l_set];
    accept = (state == IDLE) && cpu_req;
    wr_hit = accept && cpu_we && hit;
    fill   = (state == RD_MISS) && mem_ack;
  end

  // tag/data storage needs no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (wr_hit) data_mem[req_set][hit_way] <= cpu_wdata;
    if (fill) begin
      tag_mem[l_set][victim]  <= l_tag;
      data_mem[l_set][victim] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      for (int s = 0; s < SETS; s++) valid[s] <= 2'b00;
      lru       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: if (cpu_req) begin
          if (hit) lru[req_set] <= ~hit_way;
          if (cpu_we || !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= cpu_wdata;
            state     <= cpu_we ? WR_THRU : RD_MISS;
          end else begin
            cpu_rdata <= data_mem[req_set][hit_way];
            cpu_ready <= 1'b1;
          end
        end
        RD_MISS: if (mem_ack) begin
          valid[l_set][victim] <= 1'b1;
          lru[l_set]           <= ~victim;
          cpu_rdata            <= mem_rdata;
          cpu_ready            <= 1'b1;
          mem_req              <= 1'b0;
          state                <= IDLE;
        end
        WR_THRU: if (mem_ack) begin
          cpu_ready <= 1'b1;
          mem_req   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_2way.sv
// Directed bench for cache_2way: scoreboard queue of expected completions checked on cpu_ready,
// with a memory responder of programmable ack delay.
module tb_cache_2way;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, cpu_ready, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_2way #(.SET_BITS(3), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // memory model and responder
  logic [31:0] mem_model [logic [31:0]];
  int          mem_delay = 0;
  int          wcnt      = 0;
  int          mem_cnt   = 0;
  logic [31:0] last_maddr, last_mwdata;
  logic        last_mwe;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A00_0000 ^ a;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (rst && mem_req) begin
        if (wcnt >= mem_delay) begin
          wcnt        = 0;
          mem_ack     = 1'b1;
          mem_cnt++;
          last_maddr  = mem_addr;
          last_mwe    = mem_we;
          last_mwdata = mem_wdata;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_read(mem_addr);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // scoreboard
  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] rdata, maddr, mwdata;
    int          mem_ops, lat, mem_start;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   ready_cnt  = 0;
  int   accept_cyc = 0;

  function automatic void push_exp(input string tag, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] exp_rd,
                                   input int delay, input bit hit);
    exp_t e;
    e.tag       = tag;
    e.we        = we;
    e.rdata     = exp_rd;
    e.maddr     = {addr[31:2], 2'b00};
    e.mwdata    = wdata;
    e.mem_ops   = (we || !hit) ? 1 : 0;
    e.lat       = (we || !hit) ? delay + 2 : 1;
    e.mem_start = mem_cnt;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rst && cpu_ready) begin
      ready_cnt++;
      chk("ready_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk({mon_e.tag, "_latency"}, 32'(cyc - accept_cyc + 1), 32'(mon_e.lat));
        chk({mon_e.tag, "_mem_ops"}, 32'(mem_cnt - mon_e.mem_start), 32'(mon_e.mem_ops));
        if (mon_e.mem_ops != 0) begin
          chk({mon_e.tag, "_mem_addr"}, last_maddr, mon_e.maddr);
          chk({mon_e.tag, "_mem_we"}, 32'(last_mwe), 32'(mon_e.we));
          if (mon_e.we) chk({mon_e.tag, "_mem_wdata"}, last_mwdata, mon_e.mwdata);
        end
        if (!mon_e.we) chk({mon_e.tag, "_rdata"}, cpu_rdata, mon_e.rdata);
      end
    end
  end

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input int delay, input bit hit);
    int seen;
    mem_delay = delay;
    push_exp(tag, we, addr, wdata, exp_rd, delay, hit);
    seen = ready_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    accept_cyc = cyc;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FFFC; cpu_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 60 && ready_cnt == seen; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(ready_cnt != seen), 32'd1);
  endtask

  initial begin
    int seen;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #23;
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    mem_model[32'h10] = 32'hDEAD_BEEF;
    txn("ld10_miss",  1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    txn("ld10_hit",   1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    txn("ld30_miss",  1'b0, 32'h30, 32'h0, 32'h5A00_0030, 1, 1'b0);
    txn("ld50_evict", 1'b0, 32'h50, 32'h0, 32'h5A00_0050, 0, 1'b0);
    txn("ld30_hit",   1'b0, 32'h30, 32'h0, 32'h5A00_0030, 0, 1'b1);
    txn("ld10_again", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    txn("ld30_kept",  1'b0, 32'h30, 32'h0, 32'h5A00_0030, 0, 1'b1);
    txn("ld20_fill",  1'b0, 32'h20, 32'h0, 32'h5A00_0020, 1, 1'b0);
    txn("st20_hit",   1'b1, 32'h20, 32'h1234_5678, 32'h0, 2, 1'b1);
    txn("ld20_new",   1'b0, 32'h20, 32'h0, 32'h1234_5678, 0, 1'b1);
    txn("st40_miss",  1'b1, 32'h42, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    txn("ld40_noalloc", 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1, 1'b0);

    // back-to-back: second request accepted in the cycle the first completes
    push_exp("b2b_a", 1'b0, 32'h20, 32'h0, 32'h1234_5678, 0, 1'b1);
    push_exp("b2b_b", 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
    seen = ready_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    @(posedge clk); #1;
    accept_cyc = cyc; cpu_addr = 32'h40;
    @(posedge clk); #1;
    accept_cyc = cyc; cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_count", 32'(ready_cnt - seen), 32'd2);

    // reset while a read miss is pending
    mem_delay = 20;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pending_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_cpu_ready", 32'(cpu_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn("ld20_after_rst", 1'b0, 32'h20, 32'h0, 32'h1234_5678, 0, 1'b0);
    txn("ld40_after_rst", 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
    txn("ld20_rehit",     1'b0, 32'h20, 32'h0, 32'h1234_5678, 0, 1'b1);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stats_rst_hits", hit_count, 32'd0);
    chk("stats_rst_misses", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    txn("s_ld100", 1'b0, 32'h100, 32'h0, 32'h5A00_0100, 0, 1'b0);
    txn("s_ld104", 1'b0, 32'h104, 32'h0, 32'h5A00_0104, 0, 1'b0);
    txn("s_ld100h", 1'b0, 32'h100, 32'h0, 32'h5A00_0100, 0, 1'b1);
    txn("s_ld104h", 1'b0, 32'h104, 32'h0, 32'h5A00_0104, 0, 1'b1);
    txn("s_st100h", 1'b1, 32'h100, 32'h0BAD_CAFE, 32'h0, 0, 1'b1);
    chk("stats_hits", hit_count, 32'd3);
    chk("stats_misses", miss_count, 32'd2);
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
